// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and default timing for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {REL, PRS, HOLD} press_st_t;

    localparam int DEF_NCH           = 5;
    localparam int DEF_N             = 20;
    localparam int DEF_LONG_CYCLES   = 2**26;
    localparam int DEF_REPEAT_CYCLES = 2**23;

    // Hold timer only ever counts up to the larger interval minus one.
    function automatic int tmr_width(input int long_cycles, input int repeat_cycles);
        int m;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop sync, counter debounce, press/hold FSM
module btn_channel
    import btn_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in_btn,
    output logic out_btn,
    output logic rise_o,
    output logic fall_o,
    output logic long_o,
    output logic rpt_o
);

    localparam int DEB = 2**(N-1);
    localparam int TW  = tmr_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [N-1:0]  CNT_LAST  = N'(DEB - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] RPT_LAST  = TW'(REPEAT_CYCLES - 1);

    logic          sync_q;
    logic          sy;
    logic [N-1:0]  cnt;
    logic          flip;
    logic          rise_ev;
    logic          fall_ev;

    press_st_t     state;
    press_st_t     state_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic          rpt_q;
    logic          rpt_nxt;

    // flip is the edge on which the filtered level is about to change
    assign flip    = (sy != out_btn) && (cnt == CNT_LAST);
    assign rise_ev = flip & sy;
    assign fall_ev = flip & ~sy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 1'b0;
            sy      <= 1'b0;
            cnt     <= '0;
            out_btn <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            sync_q  <= in_btn;
            sy      <= sync_q;
            rise_o  <= rise_ev;
            fall_o  <= fall_ev;
            if (sy == out_btn) begin
                cnt <= '0;
            end else if (flip) begin
                out_btn <= sy;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= REL;
            tmr   <= '0;
            rpt_q <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            rpt_q <= rpt_nxt;
        end
    end

    // A debounced release wins over any long/repeat event on the same edge.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        rpt_nxt   = 1'b0;
        if (fall_ev) begin
            state_nxt = REL;
            tmr_nxt   = '0;
        end else begin
            case (state)
                REL: begin
                    if (rise_ev) begin
                        state_nxt = PRS;
                        tmr_nxt   = '0;
                    end
                end
                PRS: begin
                    if (tmr == LONG_LAST) begin
                        state_nxt = HOLD;
                        rpt_nxt   = 1'b1;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr == RPT_LAST) begin
                        rpt_nxt = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = REL;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        long_o = 1'b0;
        rpt_o  = rpt_q;
        if (state == HOLD) begin
            long_o = 1'b1;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - NCH independent button channels side by side
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NCH           = DEF_NCH,
    parameter int N             = DEF_N,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_btn,
    output logic [NCH-1:0] out_btn,
    output logic [NCH-1:0] rise_o,
    output logic [NCH-1:0] fall_o,
    output logic [NCH-1:0] long_o,
    output logic [NCH-1:0] rpt_o
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        btn_channel #(
            .N             (N),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .in_btn  (in_btn[c]),
            .out_btn (out_btn[c]),
            .rise_o  (rise_o[c]),
            .fall_o  (fall_o[c]),
            .long_o  (long_o[c]),
            .rpt_o   (rpt_o[c])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - randomized bench with a press-age reference model
module tb_btn_conditioner;

    localparam int NCH  = 2;
    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int RPT  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] in_btn;
    logic [NCH-1:0] out_btn, rise_o, fall_o, long_o, rpt_o;

    int tests = 0;
    int fails = 0;

    // model: input history, mismatch streak, edges since debounced rise
    logic [NCH-1:0] h1, h2;
    logic [NCH-1:0] e_out, e_rise, e_fall, e_long, e_rpt;
    int             streak [NCH];
    int             age    [NCH];

    btn_conditioner #(
        .NCH           (NCH),
        .N             (N),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (RPT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_btn  (in_btn),
        .out_btn (out_btn),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .long_o  (long_o),
        .rpt_o   (rpt_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        h1 = '0; h2 = '0;
        e_out = '0; e_rise = '0; e_fall = '0; e_long = '0; e_rpt = '0;
        for (int c = 0; c < NCH; c++) begin
            streak[c] = 0;
            age[c]    = 0;
        end
    endtask

    task automatic model_edge();
        logic sy;
        for (int c = 0; c < NCH; c++) begin
            sy        = h2[c];
            e_rise[c] = 1'b0;
            e_fall[c] = 1'b0;
            if (sy != e_out[c]) begin
                streak[c]++;
                if (streak[c] == DEB) begin
                    e_out[c]  = sy;
                    streak[c] = 0;
                    e_rise[c] = sy;
                    e_fall[c] = ~sy;
                end
            end else begin
                streak[c] = 0;
            end
            if (e_rise[c]) age[c] = 0;
            else if (e_out[c]) age[c]++;
            e_long[c] = e_out[c] && (age[c] >= LONG);
            e_rpt[c]  = e_out[c] && !e_rise[c] && (age[c] >= LONG) && (((age[c] - LONG) % RPT) == 0);
        end
        h2 = h1;
        h1 = in_btn;
    endtask

    task automatic check_all();
        cmp("out_btn", out_btn, e_out);
        cmp("rise_o",  rise_o,  e_rise);
        cmp("fall_o",  fall_o,  e_fall);
        cmp("long_o",  long_o,  e_long);
        cmp("rpt_o",   rpt_o,   e_rpt);
    endtask

    task automatic step(input logic [NCH-1:0] v);
        @(posedge clk);
        model_edge();
        #1 check_all();
        #1 in_btn = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) begin
            @(posedge clk);
            #1 check_all();
        end
        #1 reset = 1'b1;
    endtask

    initial begin
        int             runlen [NCH];
        logic [NCH-1:0] v;

        reset  = 1'b0;
        in_btn = '0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1 check_all();
        end
        cmp("reset_out", out_btn, 2'b00);
        cmp("reset_long", long_o, 2'b00);
        #1 reset = 1'b1;

        // bounces shorter than the debounce window never reach out_btn
        for (int w = 1; w <= 7; w++) begin
            repeat (w) step(2'b01);
            repeat ($urandom_range(1, 2)) step(2'b00);
        end
        repeat (12) step(2'b00);
        cmp("bounce_out", out_btn, 2'b00);

        // clean press: rise exactly 10 edges after the input edge
        step(2'b01);
        repeat (9) step(2'b01);
        cmp("pre_rise_out", out_btn, 2'b00);
        step(2'b01);
        cmp("rise_out", out_btn, 2'b01);
        cmp("rise_pulse", rise_o, 2'b01);

        // long press at +32 with first repeat, next repeat at +40
        repeat (31) step(2'b01);
        cmp("pre_long", long_o, 2'b00);
        step(2'b01);
        cmp("long_at_32", long_o, 2'b01);
        cmp("rpt_at_32", rpt_o, 2'b01);
        step(2'b01);
        cmp("rpt_at_33", rpt_o, 2'b00);
        repeat (6) step(2'b01);
        step(2'b01);
        cmp("rpt_at_40", rpt_o, 2'b01);
        repeat (40) step(2'b01);

        // release bounces are held; clean release falls 10 edges later
        for (int k = 1; k <= 7; k++) begin
            repeat (k) step(2'b00);
            step(2'b01);
        end
        cmp("bounce_held", out_btn, 2'b01);
        step(2'b00);
        repeat (9) step(2'b00);
        cmp("pre_fall_long", long_o, 2'b01);
        step(2'b00);
        cmp("fall_pulse", fall_o, 2'b01);
        cmp("fall_long", long_o, 2'b00);
        cmp("fall_rpt", rpt_o, 2'b00);
        cmp("fall_out", out_btn, 2'b00);
        repeat (4) step(2'b00);

        // reset in the middle of a hold, then a fresh press after release
        step(2'b01);
        repeat (44) step(2'b01);
        cmp("hold_before_reset", long_o, 2'b01);
        do_reset();
        cmp("reset_mid_out", out_btn, 2'b00);
        cmp("reset_mid_long", long_o, 2'b00);
        repeat (9) step(2'b01);
        cmp("rerise_early", out_btn, 2'b00);
        step(2'b01);
        cmp("rerise_pulse", rise_o, 2'b01);
        repeat (31) step(2'b01);
        cmp("relong_early", long_o, 2'b00);
        step(2'b01);
        cmp("relong", long_o, 2'b01);

        // both channels on the same edge, then staggered holds
        repeat (12) step(2'b00);
        step(2'b11);
        repeat (9) step(2'b11);
        cmp("dual_pre", rise_o, 2'b00);
        step(2'b11);
        cmp("dual_rise", rise_o, 2'b11);
        repeat (12) step(2'b01);
        step(2'b11);
        repeat (60) step(2'b11);
        repeat (12) step(2'b00);

        // randomized run lengths around the debounce window
        v = in_btn;
        for (int c = 0; c < NCH; c++) runlen[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (runlen[c] == 0) begin
                    v[c] = ~v[c];
                    if ($urandom_range(0, 3) == 0) runlen[c] = int'($urandom_range(9, 70));
                    else runlen[c] = int'($urandom_range(1, 9));
                end else begin
                    runlen[c]--;
                end
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
